// File: rtl/pktbuf_rd_ctrl.sv
// Read-side packet buffer controller: credited reads, RD_LAT tag pipeline, return FIFO to stream.
// Optional statistics counters are built when PKTBUF_RD_STATS_EN is defined.
module pktbuf_rd_ctrl #(
  parameter int AWIDTH     = 17,
  parameter int DWIDTH     = 520,
  parameter int RD_LAT     = 12,
  parameter int FIFO_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [AWIDTH-1:0] desc_addr,
  input  logic [7:0]        desc_len,
  input  logic [5:0]        desc_empty,
  output logic              rden,
  output logic [AWIDTH-1:0] rdaddress,
  input  logic              rd_valid,
  input  logic [DWIDTH-1:0] rddata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic [5:0]        out_empty,
  output logic              err_lat,
  output logic [31:0]       stat_pkts,
  output logic [31:0]       stat_flits,
  output logic [31:0]       stat_stalls
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {DRAIN, IDLE, READ} state_e;
  typedef struct packed {
    logic       vld;
    logic       sop;
    logic       eop;
    logic [5:0] empty;
  } tag_t;
  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [5:0]        empty;
    logic [DWIDTH-1:0] data;
  } ent_t;

  state_e            state_q, state_d;
  logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
  logic [AWIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [7:0]        remain_q, remain_d;
  logic [5:0]        empty_q, empty_d;
  logic              first_q, first_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  tag_t              pipe_q [RD_LAT];
  tag_t              tag_in;
  ent_t              mem [FIFO_DEPTH];
  ent_t              out_q, out_d, push_ent;
  logic              out_valid_q, out_valid_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     mem_cnt_q, mem_cnt_d, fifo_count;
  logic [CW:0]       used;
  logic              credit_ok, push, pop, wr_ok, overflow, load_out, mem_we, dec, err_q, err_d;

  assign fifo_count = mem_cnt_q + CW'(out_valid_q);
  assign used       = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign credit_ok  = used < (CW+1)'(FIFO_DEPTH);
  // Returns are only trusted once the post-reset drain window has flushed stale reads.
  assign push       = rd_valid && (state_q != DRAIN);
  assign pop        = out_valid_q && out_ready;
  assign overflow   = push && (fifo_count == CW'(FIFO_DEPTH));
  assign wr_ok      = push && !overflow;
  assign load_out   = !out_valid_q || pop;
  assign dec        = push && (inflight_q != '0);
  assign rdaddress  = rden ? cur_addr_q : '0;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    cur_addr_d  = cur_addr_q;
    remain_d    = remain_q;
    empty_d     = empty_q;
    first_d     = first_q;
    desc_ready  = 1'b0;
    rden        = 1'b0;
    unique case (state_q)
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + DW'(1);
        if (drain_cnt_q == DW'(RD_LAT)) state_d = IDLE;
      end
      IDLE: desc_ready = 1'b1;
      READ: begin
        if (credit_ok) begin
          rden       = 1'b1;
          cur_addr_d = cur_addr_q + AWIDTH'(1);
          remain_d   = remain_q - 8'd1;
          first_d    = 1'b0;
          if (remain_q == 8'd1) begin
            desc_ready = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = DRAIN;
    endcase
    if (desc_valid && desc_ready) begin
      cur_addr_d = desc_addr;
      remain_d   = (desc_len == 8'd0) ? 8'd1 : desc_len;
      empty_d    = desc_empty;
      first_d    = 1'b1;
      state_d    = READ;
    end
  end

  always_comb begin
    tag_in.vld   = rden;
    tag_in.sop   = first_q;
    tag_in.eop   = (remain_q == 8'd1);
    tag_in.empty = (remain_q == 8'd1) ? empty_q : 6'd0;
    push_ent     = {pipe_q[RD_LAT-1].sop, pipe_q[RD_LAT-1].eop, pipe_q[RD_LAT-1].empty, rddata};
    err_d        = err_q | (state_q != DRAIN && (rd_valid != pipe_q[RD_LAT-1].vld || overflow));
    unique case ({rden, dec})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // Output register is the FIFO head; an empty FIFO bypasses the write straight into it.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    mem_cnt_d   = mem_cnt_q;
    mem_we      = 1'b0;
    if (load_out) begin
      if (mem_cnt_q != '0) begin
        out_d       = mem[rd_ptr_q];
        out_valid_d = 1'b1;
        rd_ptr_d    = rd_ptr_q + PW'(1);
        mem_cnt_d   = mem_cnt_q - CW'(1);
      end else if (wr_ok) begin
        out_d       = push_ent;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    if (wr_ok && !(load_out && mem_cnt_q == '0)) begin
      mem_we    = 1'b1;
      wr_ptr_d  = wr_ptr_q + PW'(1);
      mem_cnt_d = mem_cnt_d + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q     <= DRAIN;
      drain_cnt_q <= '0;
      cur_addr_q  <= '0;
      remain_q    <= '0;
      empty_q     <= '0;
      first_q     <= 1'b0;
      inflight_q  <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      cur_addr_q  <= cur_addr_d;
      remain_q    <= remain_d;
      empty_q     <= empty_d;
      first_q     <= first_d;
      inflight_q  <= inflight_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      err_q       <= err_d;
      pipe_q[0]   <= tag_in;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // NOTE: the storage array is not reset; occupancy is tracked by the reset pointers and count.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= push_ent;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_q.data;
  assign out_sop   = out_q.sop;
  assign out_eop   = out_q.eop;
  assign out_empty = out_q.empty;
  assign err_lat   = err_q;

`ifdef PKTBUF_RD_STATS_EN
  logic [31:0] pkts_q, flits_q, stalls_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      pkts_q   <= '0;
      flits_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (pop) flits_q <= flits_q + 32'd1;
      if (pop && out_q.eop) pkts_q <= pkts_q + 32'd1;
      if (state_q == READ && remain_q != 8'd0 && !credit_ok) stalls_q <= stalls_q + 32'd1;
    end
  end
  assign stat_pkts   = pkts_q;
  assign stat_flits  = flits_q;
  assign stat_stalls = stalls_q;
`else
  assign stat_pkts   = '0;
  assign stat_flits  = '0;
  assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_pktbuf_rd_ctrl.sv
// Directed bench for pktbuf_rd_ctrl: descriptor table plus hand-written multi-cycle sequences,
// with a fixed-latency memory model whose latency can be skewed.
module tb_pktbuf_rd_ctrl;
  localparam int AW = 17;
  localparam int DWD = 520;
  localparam int LAT = 12;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           desc_valid = 1'b0;
  logic           desc_ready;
  logic [AW-1:0]  desc_addr = '0;
  logic [7:0]     desc_len = '0;
  logic [5:0]     desc_empty = '0;
  logic           rden;
  logic [AW-1:0]  rdaddress;
  logic           rd_valid;
  logic [DWD-1:0] rddata;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [DWD-1:0] out_data;
  logic           out_sop, out_eop;
  logic [5:0]     out_empty;
  logic           err_lat;
  logic [31:0]    stat_pkts, stat_flits, stat_stalls;

  pktbuf_rd_ctrl dut (
    .clk(clk), .rst(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_addr(desc_addr),
    .desc_len(desc_len), .desc_empty(desc_empty),
    .rden(rden), .rdaddress(rdaddress), .rd_valid(rd_valid), .rddata(rddata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
    .err_lat(err_lat),
    .stat_pkts(stat_pkts), .stat_flits(stat_flits), .stat_stalls(stat_stalls)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DWD-1:0] memf(input logic [AW-1:0] a);
    logic [DWD-1:0] d;
    d = '0;
    d[16:0] = a;
    d[519:503] = ~a;
    d[300:284] = a ^ 17'h15a5a;
    return d;
  endfunction

  // Memory model: read strobe delayed by model_lat cycles.
  int model_lat = LAT;
  bit          sh_v [16];
  bit [AW-1:0] sh_a [16];
  always @(posedge clk) begin
    sh_v[0] <= rden;
    sh_a[0] <= rdaddress;
    for (int i = 1; i < 16; i++) begin
      sh_v[i] <= sh_v[i-1];
      sh_a[i] <= sh_a[i-1];
    end
  end
  assign rd_valid = sh_v[model_lat-1];
  assign rddata   = memf(sh_a[model_lat-1]);

  typedef struct { int cyc; logic [AW-1:0] addr; } rd_rec_t;
  typedef struct { int cyc; logic sop; logic eop; logic [5:0] empty; logic [DWD-1:0] data; } beat_t;
  rd_rec_t rd_log[$];
  beat_t   beat_log[$];
  always @(negedge clk) begin
    if (rden === 1'b1) rd_log.push_back('{cyc, rdaddress});
    if (out_valid === 1'b1 && out_ready) beat_log.push_back('{cyc, out_sop, out_eop, out_empty, out_data});
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_desc(input logic [AW-1:0] a, input logic [7:0] l, input logic [5:0] e, output int t);
    t = -1;
    desc_addr = a; desc_len = l; desc_empty = e; desc_valid = 1'b1;
    for (int k = 0; k < 300 && t < 0; k++) begin
      @(negedge clk);
      if (desc_ready) t = cyc;
      tick(1);
    end
    desc_valid = 1'b0;
    check("desc_accepted", 64'(t >= 0), 1);
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int k = 0; k < budget && beat_log.size() < n; k++) tick(1);
  endtask

  task automatic count_drain(output int zeros);
    zeros = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (desc_ready) break;
      zeros++;
      @(posedge clk); #1;
    end
    tick(1);
  endtask

  typedef struct {
    logic [AW-1:0] addr; logic [7:0] len; logic [5:0] empty;
    int exp_beats; logic [AW-1:0] exp_last_addr; logic [5:0] exp_last_empty;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int t, t2, rd0, b0, zeros, bad, n_iss;
    logic [31:0] flits0, pkts0;
    logic [AW-1:0] a;
    vecs[0] = '{17'h00100, 8'd3, 6'd5,  3, 17'h00102, 6'd5};
    vecs[1] = '{17'h1ffff, 8'd2, 6'd0,  2, 17'h00000, 6'd0};
    vecs[2] = '{17'h00040, 8'd0, 6'd7,  1, 17'h00040, 6'd7};
    vecs[3] = '{17'h1fffe, 8'd4, 6'd63, 4, 17'h00001, 6'd63};
    vecs[4] = '{17'h0abcd, 8'd1, 6'd1,  1, 17'h0abcd, 6'd1};

    // Reset values, then the drain window.
    tick(2);
    @(negedge clk);
    check("rst_desc_ready", desc_ready, 0);
    check("rst_rden", rden, 0);
    check("rst_rdaddress", rdaddress, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sop_eop", {out_sop, out_eop}, 0);
    check("rst_out_empty", out_empty, 0);
    check("rst_out_data_zero", 64'(out_data == '0), 1);
    check("rst_err_lat", err_lat, 0);
    check("rst_stats", {stat_pkts, stat_flits} | 64'(stat_stalls), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    count_drain(zeros);
    check("drain_cycles", zeros, LAT + 1);

    for (int v = 0; v < 5; v++) begin
      rd0 = rd_log.size();
      b0 = beat_log.size();
      send_desc(vecs[v].addr, vecs[v].len, vecs[v].empty, t);
      wait_beats(b0 + vecs[v].exp_beats, 100);
      tick(4);
      check($sformatf("v%0d_rd_count", v), rd_log.size() - rd0, vecs[v].exp_beats);
      check($sformatf("v%0d_beat_count", v), beat_log.size() - b0, vecs[v].exp_beats);
      if (rd_log.size() >= rd0 + vecs[v].exp_beats) begin
        check($sformatf("v%0d_first_rd_cycle", v), rd_log[rd0].cyc, t + 1);
        check($sformatf("v%0d_first_rd_addr", v), rd_log[rd0].addr, vecs[v].addr);
        check($sformatf("v%0d_last_rd_addr", v), rd_log[rd0 + vecs[v].exp_beats - 1].addr, vecs[v].exp_last_addr);
      end
      if (beat_log.size() >= b0 + vecs[v].exp_beats) begin
        check($sformatf("v%0d_first_beat_cycle", v), beat_log[b0].cyc, t + 2 + LAT);
        check($sformatf("v%0d_first_sop", v), beat_log[b0].sop, 1);
        check($sformatf("v%0d_last_eop", v), beat_log[b0 + vecs[v].exp_beats - 1].eop, 1);
        check($sformatf("v%0d_last_empty", v), beat_log[b0 + vecs[v].exp_beats - 1].empty, vecs[v].exp_last_empty);
        bad = 0;
        for (int i = 0; i < vecs[v].exp_beats; i++) begin
          a = vecs[v].addr + AW'(i);
          if (beat_log[b0+i].data !== memf(a)) bad++;
          if (i > 0 && beat_log[b0+i].sop !== 1'b0) bad++;
          if (i < vecs[v].exp_beats - 1 && (beat_log[b0+i].eop !== 1'b0 || beat_log[b0+i].empty !== 6'd0)) bad++;
        end
        check($sformatf("v%0d_beat_fields", v), bad, 0);
      end
    end

    // Back-to-back single-flit descriptors, valid held high.
    rd0 = rd_log.size();
    b0 = beat_log.size();
    t = -1; t2 = -1;
    desc_addr = 17'h00600; desc_len = 8'd1; desc_empty = 6'd11; desc_valid = 1'b1;
    for (int k = 0; k < 300 && t < 0; k++) begin
      @(negedge clk);
      if (desc_ready) t = cyc;
      tick(1);
    end
    desc_addr = 17'h00700; desc_len = 8'd1; desc_empty = 6'd12;
    @(negedge clk);
    if (desc_ready) t2 = cyc;
    tick(1);
    desc_valid = 1'b0;
    check("b2b_consecutive_accept", t2, t + 1);
    wait_beats(b0 + 2, 60);
    tick(4);
    check("b2b_rd_count", rd_log.size() - rd0, 2);
    check("b2b_beat_count", beat_log.size() - b0, 2);
    if (rd_log.size() >= rd0 + 2) begin
      check("b2b_rd0_cycle", rd_log[rd0].cyc, t + 1);
      check("b2b_rd1_cycle", rd_log[rd0+1].cyc, t + 2);
    end
    if (beat_log.size() >= b0 + 2) begin
      check("b2b_beat0", {beat_log[b0].sop, beat_log[b0].eop, beat_log[b0].empty}, {2'b11, 6'd11});
      check("b2b_beat1", {beat_log[b0+1].sop, beat_log[b0+1].eop, beat_log[b0+1].empty}, {2'b11, 6'd12});
      check("b2b_data", 64'(beat_log[b0].data == memf(17'h00600) && beat_log[b0+1].data == memf(17'h00700)), 1);
    end

    // Backpressure: three 40-flit packets against a stalled sink.
    rd0 = rd_log.size();
    b0 = beat_log.size();
    flits0 = stat_flits;
    pkts0 = stat_pkts;
    out_ready = 1'b0;
    send_desc(17'h02000, 8'd40, 6'd3, t);
    tick(100);
    check("bp_issue_cap", rd_log.size() - rd0, 32);
    check("bp_err_during_stall", err_lat, 0);
`ifdef PKTBUF_RD_STATS_EN
    check("bp_stalls_nonzero", 64'(stat_stalls != 32'd0), 1);
`endif
    out_ready = 1'b1;
    send_desc(17'h03000, 8'd40, 6'd4, t);
    send_desc(17'h04000, 8'd40, 6'd5, t);
    wait_beats(b0 + 120, 400);
    tick(4);
    check("bp_beat_count", beat_log.size() - b0, 120);
    check("bp_err_after", err_lat, 0);
    if (beat_log.size() >= b0 + 120) begin
      bad = 0;
      for (int p = 0; p < 3; p++) begin
        for (int i = 0; i < 40; i++) begin
          a = 17'h02000 + AW'(p * 17'h01000) + AW'(i);
          if (beat_log[b0+p*40+i].data !== memf(a)) bad++;
          if (beat_log[b0+p*40+i].sop !== (i == 0)) bad++;
          if (beat_log[b0+p*40+i].eop !== (i == 39)) bad++;
          if (beat_log[b0+p*40+i].empty !== ((i == 39) ? 6'(p + 3) : 6'd0)) bad++;
        end
      end
      check("bp_order_fields", bad, 0);
      check("bp_no_bubbles", beat_log[b0+119].cyc - beat_log[b0].cyc, 119);
    end
`ifdef PKTBUF_RD_STATS_EN
    check("bp_stat_flits", stat_flits - flits0, 120);
    check("bp_stat_pkts", stat_pkts - pkts0, 3);
`else
    check("stats_tied_off", {stat_pkts, stat_flits} | 64'(stat_stalls), 0);
`endif

    // Reset one cycle after the 5th issue of a 10-flit packet.
    b0 = beat_log.size();
    send_desc(17'h00500, 8'd10, 6'd2, t);
    n_iss = 0;
    for (int k = 0; k < 60 && n_iss < 5; k++) begin
      @(negedge clk);
      if (rden) n_iss++;
      tick(1);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    count_drain(zeros);
    check("mid_rst_drain_cycles", zeros, LAT + 1);
    tick(30);
    check("mid_rst_no_beats", beat_log.size() - b0, 0);
    check("mid_rst_err_lat", err_lat, 0);
    send_desc(17'h00900, 8'd2, 6'd9, t);
    wait_beats(b0 + 2, 60);
    tick(4);
    check("mid_rst_recover_beats", beat_log.size() - b0, 2);
    if (beat_log.size() >= b0 + 2) begin
      check("mid_rst_recover_cycle", beat_log[b0].cyc, t + 2 + LAT);
      check("mid_rst_recover_data", 64'(beat_log[b0].data == memf(17'h00900) && beat_log[b0+1].eop), 1);
    end

    // Memory returning one cycle early.
    model_lat = LAT - 1;
    send_desc(17'h00a00, 8'd2, 6'd0, t);
    tick(25);
    check("lat_err_set", err_lat, 1);
    tick(20);
    check("lat_err_sticky", err_lat, 1);
    model_lat = LAT;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(LAT + 2);
    check("lat_err_cleared_by_reset", err_lat, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
